mc_req_arb: RTL and testbench
=============================

MC_REQ_ARB -- requirements
Module: mc_req_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters; fixed at 4, and the tag width is 2 bits.
REQ-002 Parameter TAG_LSB, default 30, low bit of the 2-bit requester tag inside the 32-bit load rdctl.
REQ-003 Parameter MAX_OUT, default 63, maximum outstanding loads per requester (6-bit counters).
REQ-004 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-005 r_reset  in  1  reset, synchronous, active-high.
REQ-006 req_ld  in  4  per-requester load request, held with its data until acked.
REQ-007 req_st  in  4  per-requester store request, held with its data until acked.
REQ-008 req_vadr  in  4x48  per-requester virtual address; requester i uses bits [48i+47:48i].
REQ-009 req_wrd_rdctl  in  4x64  per-requester store data or load rdctl; load rdctl lives in the low 32 bits.
REQ-010 req_ack  out  4  one-hot pulse; the request is consumed in this cycle.
REQ-011 mc_req_ld, mc_req_st  out  1 each  registered request strobes to the MC.
REQ-012 mc_req_vadr  out  48  registered address to the MC.
REQ-013 mc_req_wrd_rdctl  out  64  registered write data or tagged rdctl to the MC.
REQ-014 mc_rd_rq_stall, mc_wr_rq_stall  in  1 each  MC read and write back-pressure.
REQ-015 mc_rsp_push  in  1  response valid; mc_rsp_rdctl  in  32; mc_rsp_data  in  64.
REQ-016 mc_rsp_stall  out  1  response back-pressure to the MC.
REQ-017 rsp_push  out  4  per-requester response strobe; rsp_rdctl  out  32  and rsp_data  out  64 are shared by all requesters.
REQ-018 rsp_stall  in  4  per-requester response back-pressure.
REQ-019 idle  out  1  no request pending, no request registered, no load outstanding.
REQ-020 err  out  1  sticky protocol-error flag.

Function
REQ-021 Eligibility: requester i SHALL be eligible for a load when req_ld[i]=1, mc_rd_rq_stall=0 and out_cnt[i] < MAX_OUT.
REQ-022 Eligibility: requester i SHALL be eligible for a store when req_st[i]=1, req_ld[i]=0 and mc_wr_rq_stall=0.
REQ-023 Grant: at most one requester SHALL be granted per cycle, selected from the eligible set, with req_ack[i] asserted combinationally in the same cycle.
REQ-024 Request latency: the granted request SHALL appear on mc_req_* exactly one cycle after req_ack.
REQ-025 Idle strobes: mc_req_ld and mc_req_st SHALL be 0 in every cycle that follows a no-grant cycle.
REQ-026 Load tagging: mc_req_wrd_rdctl SHALL carry {32'b0, rdctl} with bits [TAG_LSB+1:TAG_LSB] replaced by i.
REQ-027 Store pass-through: store data SHALL pass to mc_req_wrd_rdctl unmodified.
REQ-028 Outstanding count: out_cnt[i] SHALL increment on a load ack to i and decrement on a response routed to i.
REQ-029 Outstanding count, simultaneous events: a simultaneous load ack and response for the same i SHALL leave out_cnt[i] unchanged.
REQ-030 Response routing: on mc_rsp_push with tag t = mc_rsp_rdctl[TAG_LSB+1:TAG_LSB], the block SHALL assert rsp_push[t] one cycle later.
REQ-031 Response payload: rsp_data SHALL equal mc_rsp_data, and rsp_rdctl SHALL equal mc_rsp_rdctl with the tag bits cleared.
REQ-032 Response back-pressure: mc_rsp_stall SHALL be the combinational OR of rsp_stall.
REQ-033 Response slack: requesters SHALL accept responses for up to one cycle beyond the MC's own post-stall slack; responses are never dropped.
REQ-034 Protocol errors: err SHALL set on req_ld[i] and req_st[i] both high, or on a response whose tag t has out_cnt[t]=0.
REQ-035 Protocol-error behaviour: in the dual-request case the load is served; in the zero-count case the response is still routed and out_cnt holds at 0.
REQ-036 Saturation: a requester with out_cnt=MAX_OUT SHALL be skipped while its load stays pending, without blocking the other requesters.
REQ-037 Idle: idle SHALL be 1 iff req_ld, req_st, mc_req_ld and mc_req_st are all 0 and every out_cnt is 0.

Reset
REQ-038 While r_reset=1, mc_req_ld, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl, rsp_push, rsp_rdctl, rsp_data, req_ack, err, every out_cnt and the round-robin pointer SHALL be 0.
REQ-039 While r_reset=1, idle SHALL be 1, and responses arriving during reset SHALL be dropped.
REQ-040 Reset asserted mid-operation SHALL abandon outstanding-load accounting; the first grant after reset release is allowed on the following cycle.

Configuration
REQ-041 With MC_REQ_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer p, and after a grant to i, p becomes (i+1) mod 4.
REQ-042 Without MC_REQ_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 highest and no pointer logic.

Verification
REQ-043 Basic load: requester 2 load at vadr 0x1000 with rdctl 0x5 -> ack the same cycle, next cycle mc_req_ld=1, vadr 0x1000, wrd_rdctl 0x80000005.
REQ-044 Response routing: response rdctl 0x80000005 with data 0xAB -> rsp_push=4'b0100 one cycle later with rsp_rdctl 0x5, rsp_data 0xAB, and out_cnt[2] back to 0.
REQ-045 Contention: all 4 requesters hold loads with RR_EN defined -> acks in order 0,1,2,3,0.
REQ-046 Contention: all 4 requesters hold loads without RR_EN -> requester 0 acked every cycle.
REQ-047 Saturation: 63 unanswered loads from requester 1 -> requester 1 receives no further ack while requester 3 keeps being acked; one response to 1 re-enables it.
REQ-048 Stalls: mc_rd_rq_stall=1 with loads pending -> no ack and no mc_req_ld, while a pending store is still acked.
REQ-049 Protocol error: response with tag 3 while out_cnt[3]=0 -> err=1 and stays set until r_reset.

Source files
------------

// File: rtl/mc_req_arb.sv
// mc_req_arb: arbitrates four requesters' loads/stores onto one MC request port and
// routes tagged MC responses back. Define MC_REQ_ARB_RR_EN for round-robin arbitration.
module mc_req_arb #(
  parameter int NREQ    = 4,
  parameter int TAG_LSB = 30,
  parameter int MAX_OUT = 63
) (
  input  logic               clk,
  input  logic               r_reset,
  input  logic [NREQ-1:0]    req_ld,
  input  logic [NREQ-1:0]    req_st,
  input  logic [NREQ*48-1:0] req_vadr,
  input  logic [NREQ*64-1:0] req_wrd_rdctl,
  output logic [NREQ-1:0]    req_ack,
  output logic               mc_req_ld,
  output logic               mc_req_st,
  output logic [47:0]        mc_req_vadr,
  output logic [63:0]        mc_req_wrd_rdctl,
  input  logic               mc_rd_rq_stall,
  input  logic               mc_wr_rq_stall,
  input  logic               mc_rsp_push,
  input  logic [31:0]        mc_rsp_rdctl,
  input  logic [63:0]        mc_rsp_data,
  output logic               mc_rsp_stall,
  output logic [NREQ-1:0]    rsp_push,
  output logic [31:0]        rsp_rdctl,
  output logic [63:0]        rsp_data,
  input  logic [NREQ-1:0]    rsp_stall,
  output logic               idle,
  output logic               err
);

  localparam int            TW      = 2;
  localparam int            CW      = 6;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

  function automatic logic [31:0] tag_set(input logic [31:0] rdctl, input logic [TW-1:0] tag);
    logic [31:0] v;
    v = rdctl;
    v[TAG_LSB +: TW] = tag;
    return v;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [TW-1:0] idx);
    logic [NREQ-1:0] v;
    v = {NREQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [CW-1:0]   out_cnt_r [NREQ];
  logic [NREQ-1:0] ld_elig_s;
  logic [NREQ-1:0] st_elig_s;
  logic [NREQ-1:0] elig_s;
  logic [NREQ-1:0] ack_s;
  logic [NREQ-1:0] rsp_hit_s;
  logic            gnt_vld_s;
  logic            gnt_ld_s;
  logic [TW-1:0]   gnt_idx_s;
  logic [47:0]     sel_vadr_s;
  logic [63:0]     sel_wrd_s;
  logic            rsp_acc_s;
  logic [TW-1:0]   rsp_tag_s;
  logic            dual_s;
  logic            zero_rsp_s;
  logic            cnt_zero_s;

  logic            mc_req_ld_r;
  logic            mc_req_st_r;
  logic [47:0]     mc_req_vadr_r;
  logic [63:0]     mc_req_wrd_r;
  logic [NREQ-1:0] rsp_push_r;
  logic [31:0]     rsp_rdctl_r;
  logic [63:0]     rsp_data_r;
  logic            err_r;

  // Per-requester eligibility; a held load shadows a store from the same requester.
  always_comb begin
    ld_elig_s = {NREQ{1'b0}};
    st_elig_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      ld_elig_s[i] = ~r_reset & req_ld[i] & ~mc_rd_rq_stall & (out_cnt_r[i] < CNT_MAX);
      st_elig_s[i] = ~r_reset & req_st[i] & ~req_ld[i] & ~mc_wr_rq_stall;
    end
    elig_s = ld_elig_s | st_elig_s;
  end

`ifdef MC_REQ_ARB_RR_EN
  logic [TW-1:0] rr_ptr_r;
  logic [TW-1:0] cand_s;

  // Round-robin pick: scan backwards so the first eligible slot from the pointer wins.
  always_comb begin
    gnt_idx_s = {TW{1'b0}};
    cand_s    = {TW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_s    = rr_ptr_r + TW'(k);
      gnt_idx_s = elig_s[cand_s] ? cand_s : gnt_idx_s;
    end
  end

  // Pointer moves to the slot after the last grant.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      rr_ptr_r <= 2'd0;
    end else if (gnt_vld_s) begin
      rr_ptr_r <= gnt_idx_s + 2'd1;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  // Fixed priority pick: requester 0 highest.
  always_comb begin
    gnt_idx_s = {TW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      gnt_idx_s = elig_s[k] ? TW'(k) : gnt_idx_s;
    end
  end
`endif

  // Grant decode, request payload mux and response-side decode.
  always_comb begin
    gnt_vld_s  = |elig_s;
    gnt_ld_s   = gnt_vld_s & ld_elig_s[gnt_idx_s];
    ack_s      = gnt_vld_s ? onehot(gnt_idx_s) : {NREQ{1'b0}};
    sel_vadr_s = 48'd0;
    sel_wrd_s  = 64'd0;
    for (int i = 0; i < NREQ; i++) begin
      sel_vadr_s = (gnt_idx_s == TW'(i)) ? req_vadr[i*48 +: 48] : sel_vadr_s;
      sel_wrd_s  = (gnt_idx_s != TW'(i)) ? sel_wrd_s :
                   gnt_ld_s ? {32'd0, tag_set(req_wrd_rdctl[i*64 +: 32], TW'(i))} :
                              req_wrd_rdctl[i*64 +: 64];
    end
    rsp_acc_s  = mc_rsp_push & ~r_reset;
    rsp_tag_s  = mc_rsp_rdctl[TAG_LSB +: TW];
    rsp_hit_s  = rsp_acc_s ? onehot(rsp_tag_s) : {NREQ{1'b0}};
    dual_s     = |(req_ld & req_st);
    zero_rsp_s = rsp_acc_s & (out_cnt_r[rsp_tag_s] == {CW{1'b0}});
    cnt_zero_s = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      cnt_zero_s = cnt_zero_s & (out_cnt_r[i] == {CW{1'b0}});
    end
  end

  // Outstanding-load counters; a response to a zero count cannot underflow.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (r_reset) begin
        out_cnt_r[i] <= 6'd0;
      end else begin
        case ({ack_s[i] & ld_elig_s[i], rsp_hit_s[i]})
          2'b10:   out_cnt_r[i] <= out_cnt_r[i] + 6'd1;
          2'b01:   out_cnt_r[i] <= (out_cnt_r[i] == 6'd0) ? 6'd0 : out_cnt_r[i] - 6'd1;
          default: out_cnt_r[i] <= out_cnt_r[i];
        endcase
      end
    end
  end

  // MC request register: strobes follow the grant, payload holds between grants.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      mc_req_ld_r   <= 1'b0;
      mc_req_st_r   <= 1'b0;
      mc_req_vadr_r <= 48'd0;
      mc_req_wrd_r  <= 64'd0;
    end else if (gnt_vld_s) begin
      mc_req_ld_r   <= gnt_ld_s;
      mc_req_st_r   <= ~gnt_ld_s;
      mc_req_vadr_r <= sel_vadr_s;
      mc_req_wrd_r  <= sel_wrd_s;
    end else begin
      mc_req_ld_r   <= 1'b0;
      mc_req_st_r   <= 1'b0;
      mc_req_vadr_r <= mc_req_vadr_r;
      mc_req_wrd_r  <= mc_req_wrd_r;
    end
  end

  // Response register: always accepted, the requester side absorbs the extra cycle of slack.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      rsp_push_r  <= {NREQ{1'b0}};
      rsp_rdctl_r <= 32'd0;
      rsp_data_r  <= 64'd0;
    end else if (rsp_acc_s) begin
      rsp_push_r  <= rsp_hit_s;
      rsp_rdctl_r <= tag_set(mc_rsp_rdctl, 2'd0);
      rsp_data_r  <= mc_rsp_data;
    end else begin
      rsp_push_r  <= {NREQ{1'b0}};
      rsp_rdctl_r <= rsp_rdctl_r;
      rsp_data_r  <= rsp_data_r;
    end
  end

  // Sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | dual_s | zero_rsp_s;
    end
  end

  // Idle and back-pressure are combinational views of the current state.
  always_comb begin
    idle         = r_reset | (~|req_ld & ~|req_st & ~mc_req_ld_r & ~mc_req_st_r & cnt_zero_s);
    mc_rsp_stall = |rsp_stall;
  end

  assign req_ack          = ack_s;
  assign mc_req_ld        = mc_req_ld_r;
  assign mc_req_st        = mc_req_st_r;
  assign mc_req_vadr      = mc_req_vadr_r;
  assign mc_req_wrd_rdctl = mc_req_wrd_r;
  assign rsp_push         = rsp_push_r;
  assign rsp_rdctl        = rsp_rdctl_r;
  assign rsp_data         = rsp_data_r;
  assign err              = err_r;

endmodule

// File: tb/tb_mc_req_arb.sv
// tb_mc_req_arb: directed and randomized checks of mc_req_arb against a cycle-level
// behavioural model (outstanding counts, arbitration order, tagging, routing, errors).
module tb_mc_req_arb;

  logic         clk = 1'b0;
  logic         r_reset;
  logic [3:0]   req_ld, req_st, req_ack, rsp_push, rsp_stall;
  logic [191:0] req_vadr;
  logic [255:0] req_wrd_rdctl;
  logic         mc_req_ld, mc_req_st, mc_rd_rq_stall, mc_wr_rq_stall, mc_rsp_push;
  logic [47:0]  mc_req_vadr;
  logic [63:0]  mc_req_wrd_rdctl, mc_rsp_data, rsp_data;
  logic [31:0]  mc_rsp_rdctl, rsp_rdctl;
  logic         mc_rsp_stall, idle, err;

  mc_req_arb dut (
    .clk(clk), .r_reset(r_reset), .req_ld(req_ld), .req_st(req_st), .req_vadr(req_vadr),
    .req_wrd_rdctl(req_wrd_rdctl), .req_ack(req_ack), .mc_req_ld(mc_req_ld),
    .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
    .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data),
    .mc_rsp_stall(mc_rsp_stall), .rsp_push(rsp_push), .rsp_rdctl(rsp_rdctl),
    .rsp_data(rsp_data), .rsp_stall(rsp_stall), .idle(idle), .err(err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_pass = 0, n_fail = 0;
  int          m_cnt[4];
  int          m_ptr;
  bit          m_err, e_ld, e_st;
  logic [47:0] e_vadr;
  logic [63:0] e_wrd, e_rsp_data;
  logic [3:0]  e_rsp_push, last_ack;
  logic [31:0] e_rsp_rdctl;
  logic [3:0]  seq [5];
  int          guard, rs, rt;
  bit          found;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: which requester the rules pick this cycle (-1 = none).
  function automatic int model_pick();
    bit e[4];
    if (r_reset) return -1;
    for (int i = 0; i < 4; i++)
      e[i] = (req_ld[i] && !mc_rd_rq_stall && m_cnt[i] < 63) ||
             (req_st[i] && !req_ld[i] && !mc_wr_rq_stall);
`ifdef MC_REQ_ARB_RR_EN
    for (int k = 0; k < 4; k++) if (e[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`else
    for (int i = 0; i < 4; i++) if (e[i]) return i;
`endif
    return -1;
  endfunction

  function automatic bit model_idle();
    if (r_reset) return 1'b1;
    if (req_ld != 4'd0 || req_st != 4'd0 || e_ld || e_st) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_cnt[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update(input int g);
    int t;
    bit inc, dec;
    if (r_reset) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_ptr = 0; m_err = 0; e_ld = 0; e_st = 0; e_vadr = 48'd0; e_wrd = 64'd0;
      e_rsp_push = 4'd0; e_rsp_rdctl = 32'd0; e_rsp_data = 64'd0;
      return;
    end
    t = int'(mc_rsp_rdctl >> 30);
    if ((req_ld & req_st) != 4'd0) m_err = 1;
    if (mc_rsp_push && m_cnt[t] == 0) m_err = 1;
    for (int i = 0; i < 4; i++) begin
      inc = (g == i) && req_ld[i];
      dec = mc_rsp_push && (t == i);
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
    end
    e_ld = (g >= 0) && req_ld[g];
    e_st = (g >= 0) && !req_ld[g];
    if (g >= 0) begin
      e_vadr = req_vadr[g*48 +: 48];
      e_wrd  = req_ld[g] ? {32'd0, (req_wrd_rdctl[g*64 +: 32] & 32'h3FFF_FFFF) | (32'(g) << 30)}
                         : req_wrd_rdctl[g*64 +: 64];
      m_ptr  = (g + 1) % 4;
    end
    e_rsp_push = mc_rsp_push ? 4'(1 << t) : 4'd0;
    if (mc_rsp_push) begin
      e_rsp_rdctl = mc_rsp_rdctl & 32'h3FFF_FFFF;
      e_rsp_data  = mc_rsp_data;
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic step();
    int g;
    logic [3:0] ea;
    bit rst;
    @(negedge clk);
    g  = model_pick();
    ea = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ack", 64'(req_ack), 64'(ea));
    chk("mc_rsp_stall", 64'(mc_rsp_stall), 64'(|rsp_stall));
    chk("idle", 64'(idle), 64'(model_idle()));
    last_ack = req_ack;
    rst = r_reset;
    @(posedge clk);
    model_update(g);
    #1;
    chk("mc_req_ld", 64'(mc_req_ld), 64'(e_ld));
    chk("mc_req_st", 64'(mc_req_st), 64'(e_st));
    chk("err", 64'(err), 64'(m_err));
    chk("rsp_push", 64'(rsp_push), 64'(e_rsp_push));
    if (e_ld || e_st || rst) begin
      chk("mc_req_vadr", 64'(mc_req_vadr), 64'(e_vadr));
      chk("mc_req_wrd_rdctl", mc_req_wrd_rdctl, e_wrd);
    end
    if (e_rsp_push != 4'd0 || rst) begin
      chk("rsp_rdctl", 64'(rsp_rdctl), 64'(e_rsp_rdctl));
      chk("rsp_data", rsp_data, e_rsp_data);
    end
    req_ld = req_ld & ~ea;
    req_st = req_st & ~ea;
    mc_rsp_push = 1'b0;
  endtask

  task automatic do_reset();
    r_reset = 1'b1;
    step();
    r_reset = 1'b0;
  endtask

  task automatic drain();
    int gd;
    gd = 0;
    req_ld = 4'd0;
    req_st = 4'd0;
    for (int t = 0; t < 4; t++) begin
      while (m_cnt[t] > 0 && gd < 400) begin
        mc_rsp_push  = 1'b1;
        mc_rsp_rdctl = {2'(t), 30'($urandom)};
        mc_rsp_data  = {$urandom, $urandom};
        step();
        gd++;
      end
    end
  endtask

  task automatic fill_data();
    for (int i = 0; i < 4; i++) begin
      req_vadr[i*48 +: 48]      = 48'({$urandom, $urandom});
      req_wrd_rdctl[i*64 +: 64] = {$urandom, $urandom};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    r_reset = 1'b1; req_ld = 4'd0; req_st = 4'd0; req_vadr = 192'd0; req_wrd_rdctl = 256'd0;
    mc_rd_rq_stall = 1'b0; mc_wr_rq_stall = 1'b0; rsp_stall = 4'd0;
    mc_rsp_push = 1'b1; mc_rsp_rdctl = 32'h8000_0001; mc_rsp_data = 64'h55;

    // Reset: responses arriving now are dropped.
    step();
    mc_rsp_push = 1'b1;
    step();
    chk("reset_rsp_dropped", 64'(rsp_push), 64'd0);
    r_reset = 1'b0;

    // Basic load from requester 2 and its response.
    req_ld[2] = 1'b1;
    req_vadr[2*48 +: 48] = 48'h1000;
    req_wrd_rdctl[2*64 +: 64] = 64'h5;
    step();
    chk("basic_ack", 64'(last_ack), 64'h4);
    chk("basic_vadr", 64'(mc_req_vadr), 64'h1000);
    chk("basic_wrd", mc_req_wrd_rdctl, 64'h8000_0005);
    mc_rsp_push = 1'b1; mc_rsp_rdctl = 32'h8000_0005; mc_rsp_data = 64'hAB; rsp_stall = 4'b0100;
    step();
    chk("basic_rsp_push", 64'(rsp_push), 64'h4);
    chk("basic_rsp_rdctl", 64'(rsp_rdctl), 64'h5);
    chk("basic_rsp_data", rsp_data, 64'hAB);
    rsp_stall = 4'd0;
    step();

    // Contention: all four hold loads.
    do_reset();
`ifdef MC_REQ_ARB_RR_EN
    seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
`else
    seq = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`endif
    fill_data();
    for (int k = 0; k < 5; k++) begin
      req_ld = 4'hF;
      step();
      chk("contention_order", 64'(last_ack), 64'(seq[k]));
    end
    drain();

    // Saturation of requester 1 while requester 3 keeps going.
    do_reset();
    fill_data();
    guard = 0;
    while (m_cnt[1] < 63 && guard < 200) begin
      req_ld = 4'b0010;
      step();
      guard++;
    end
    for (int k = 0; k < 4; k++) begin
      req_ld = 4'b1010;
      step();
      chk("sat_skip", 64'(last_ack), 64'h8);
    end
    req_ld = 4'b1010;
    mc_rsp_push = 1'b1; mc_rsp_rdctl = 32'h4000_0000; mc_rsp_data = 64'h1;
    step();
    req_ld = 4'b1010;
    step();
    chk("sat_reenable", 64'(last_ack), 64'h2);
    drain();

    // Read/write back-pressure.
    fill_data();
    mc_rd_rq_stall = 1'b1; req_ld = 4'b0011; req_st = 4'b0100;
    step();
    chk("st_under_rdstall", 64'(last_ack), 64'h4);
    step();
    chk("rdstall_noack", 64'(last_ack), 64'h0);
    chk("rdstall_no_mcld", 64'(mc_req_ld), 64'h0);
    mc_rd_rq_stall = 1'b0;
    step();
    chk("rdstall_release", 64'(last_ack), 64'h1);
    req_ld = 4'd0; req_st = 4'b1000; mc_wr_rq_stall = 1'b1;
    step();
    chk("wrstall_noack", 64'(last_ack), 64'h0);
    mc_wr_rq_stall = 1'b0;
    step();
    chk("wrstall_release", 64'(last_ack), 64'h8);
    drain();

    // Protocol errors: zero-count response, then dual request.
    mc_rsp_push = 1'b1; mc_rsp_rdctl = 32'hC000_0077; mc_rsp_data = 64'h3;
    step();
    chk("zero_rsp_err", 64'(err), 64'h1);
    chk("zero_rsp_routed", 64'(rsp_push), 64'h8);
    for (int k = 0; k < 3; k++) step();
    chk("err_sticky", 64'(err), 64'h1);
    do_reset();
    chk("err_cleared", 64'(err), 64'h0);
    req_ld = 4'b0001; req_st = 4'b0001;
    step();
    chk("dual_ld_served", 64'(mc_req_ld), 64'h1);
    chk("dual_err", 64'(err), 64'h1);

    // Reset mid-operation abandons accounting; grant allowed right after release.
    req_ld = 4'b0110;
    step();
    step();
    r_reset = 1'b1; mc_rsp_push = 1'b1; mc_rsp_rdctl = 32'h0;
    step();
    r_reset = 1'b0; req_ld = 4'b0001;
    step();
    chk("first_after_reset", 64'(last_ack), 64'h1);
    drain();

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_ld[i] && !req_st[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 0) req_ld[i] = 1'b1;
          else req_st[i] = 1'b1;
          req_vadr[i*48 +: 48]      = 48'({$urandom, $urandom});
          req_wrd_rdctl[i*64 +: 64] = {$urandom, $urandom};
        end
      end
      mc_rd_rq_stall = ($urandom_range(0, 3) == 0);
      mc_wr_rq_stall = ($urandom_range(0, 3) == 0);
      rsp_stall      = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rs = $urandom_range(0, 3);
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
          rt = (rs + k) % 4;
          if (!found && m_cnt[rt] > 0) begin
            found        = 1'b1;
            mc_rsp_push  = 1'b1;
            mc_rsp_rdctl = {2'(rt), 30'($urandom)};
            mc_rsp_data  = {$urandom, $urandom};
          end
        end
      end
      step();
    end
    mc_rd_rq_stall = 1'b0; mc_wr_rq_stall = 1'b0; rsp_stall = 4'd0;
    while (req_ld != 4'd0 || req_st != 4'd0) step();
    drain();
    step();
    @(negedge clk);
    chk("idle_final", 64'(idle), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
